// File: rtl/led_array_pkg.sv
// Shared FSM state type, default geometry and a small constant helper for the LED array scan path.
package led_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ON    = 2'd3
    } scan_state_e;

    localparam int DEF_ROWS = 32;
    localparam int DEF_COLS = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_frame_dpbuf.sv
// Double-buffered frame store: writes go to the back bank, the registered read port serves the front bank.
module led_frame_dpbuf
    import led_array_pkg::*;
#(
    parameter  int ROWS  = DEF_ROWS,
    parameter  int COLS  = DEF_COLS,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_WR_EN,
    input  logic [ROW_W-1:0] i_WR_ROW,
    input  logic [COLS-1:0]  i_WR_DATA,
    input  logic             i_RD_EN,
    input  logic [ROW_W-1:0] i_RD_ROW,
    input  logic             i_SWAP,
    output logic [COLS-1:0]  o_RD_DATA
);

    logic [COLS-1:0] bank0_q [ROWS];
    logic [COLS-1:0] bank1_q [ROWS];
    logic [COLS-1:0] rd_q;
    logic            sel_q;
    logic            wr_ok_s;

    // Row addresses beyond the last row are dropped; a full power-of-two address space needs no check.
    generate
        if ((1 << ROW_W) == ROWS) begin : g_full_range
            assign wr_ok_s = 1'b1;
        end else begin : g_part_range
            assign wr_ok_s = ({1'b0, i_WR_ROW} < (ROW_W + 1)'(ROWS));
        end
    endgenerate

    // Back-bank write port; sel_q=0 means bank0 is front, so writes land in bank1.
    always_ff @(posedge i_CLK) begin
        if (i_WR_EN && wr_ok_s) begin
            if (sel_q) begin
                bank0_q[i_WR_ROW] <= i_WR_DATA;
            end else begin
                bank1_q[i_WR_ROW] <= i_WR_DATA;
            end
        end
    end

    // Registered front-bank read and the bank-select bit.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            rd_q  <= {COLS{1'b0}};
            sel_q <= 1'b0;
        end else begin
            if (i_RD_EN) begin
                rd_q <= sel_q ? bank1_q[i_RD_ROW] : bank0_q[i_RD_ROW];
            end
            if (i_SWAP) begin
                sel_q <= ~sel_q;
            end
        end
    end

    assign o_RD_DATA = rd_q;

endmodule

// File: rtl/led_scan_scheduler.sv
// Row-scan sequencer for the LED array: blank, load, lit phases per row with frame-aligned buffer swaps.
// Optional LED_SCAN_BRIGHTNESS_EN adds i_BRIGHT to shorten the lit part of each ON phase.
module led_scan_scheduler
    import led_array_pkg::*;
#(
    parameter  int ROWS      = DEF_ROWS,
    parameter  int COLS      = DEF_COLS,
    parameter  int BLANK_CYC = 4,
    parameter  int ON_CYC    = 64,
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_ENA_p,
    input  logic             i_WR_EN,
    input  logic [ROW_W-1:0] i_WR_ROW,
    input  logic [COLS-1:0]  i_WR_DATA,
    input  logic             i_SWAP_REQ,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [7:0]       i_BRIGHT,
`endif
    output logic [COLS-1:0]  o_LED,
    output logic [ROW_W-1:0] o_ROW,
    output logic             o_BLANK,
    output logic             o_TOGGLE_SYNC,
    output logic             o_HEAD_FLAG,
    output logic             o_SWAP_ACK
);

    localparam int MAX_CYC = max_int(BLANK_CYC, ON_CYC);
    localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    scan_state_e      state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             toggle_q, toggle_d;
    logic             head_q, head_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic             blank_q, blank_d;
    logic [COLS-1:0]  led_q, led_d;

    logic             last_blank_s, last_on_s, last_row_s;
    logic             swap_apply_s, rd_en_s, lit_s;
    logic [COLS-1:0]  rd_data_s;

    led_frame_dpbuf #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_dpbuf (
        .i_CLK     (i_CLK),
        .i_RESET   (i_RESET),
        .i_WR_EN   (i_WR_EN),
        .i_WR_ROW  (i_WR_ROW),
        .i_WR_DATA (i_WR_DATA),
        .i_RD_EN   (rd_en_s),
        .i_RD_ROW  (row_q),
        .i_SWAP    (swap_apply_s),
        .o_RD_DATA (rd_data_s)
    );

`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [7:0] bright_q;

    // Brightness is captured together with the row data so it stays constant for the whole ON phase.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            bright_q <= 8'd0;
        end else if (rd_en_s) begin
            bright_q <= i_BRIGHT;
        end else begin
            bright_q <= bright_q;
        end
    end

    assign lit_s = (32'(phase_d) < 32'(bright_q));
`else
    assign lit_s = 1'b1;
`endif

    // Next-state, row/sync bookkeeping, swap handling and next output values.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        toggle_d     = toggle_q;
        head_d       = head_q;
        last_blank_s = (phase_q == PH_W'(BLANK_CYC - 1));
        last_on_s    = (phase_q == PH_W'(ON_CYC - 1));
        last_row_s   = (row_q == ROW_W'(ROWS - 1));

        case (state_q)
            ST_IDLE: begin
                if (i_ENA_p) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BLANK: begin
                if (last_blank_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_LOAD: begin
                state_d = ST_ON;
            end
            ST_ON: begin
                if (last_on_s) begin
                    row_d   = last_row_s ? {ROW_W{1'b0}} : (row_q + ROW_W'(1));
                    state_d = i_ENA_p ? ST_BLANK : ST_IDLE;
                end else begin
                    state_d = ST_ON;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_BLANK) && (state_q != ST_BLANK)) begin
            toggle_d = ~toggle_q;
            head_d   = (row_d == {ROW_W{1'b0}});
        end else begin
            toggle_d = toggle_q;
            head_d   = head_q;
        end

        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            phase_d = {PH_W{1'b0}};
        end else begin
            phase_d = phase_q + PH_W'(1);
        end

        // A swap is only legal between frames, or at once while the scan is parked.
        swap_apply_s = pending_q &&
                       (((state_q == ST_ON) && last_on_s && last_row_s) || (state_q == ST_IDLE));
        if (i_SWAP_REQ) begin
            pending_d = 1'b1;
        end else if (swap_apply_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        ack_d = swap_apply_s;

        rd_en_s = (state_d == ST_LOAD);
        if ((state_d == ST_ON) && lit_s) begin
            led_d   = rd_data_s;
            blank_d = 1'b0;
        end else begin
            led_d   = {COLS{1'b0}};
            blank_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q   <= ST_IDLE;
            phase_q   <= {PH_W{1'b0}};
            row_q     <= {ROW_W{1'b0}};
            toggle_q  <= 1'b0;
            head_q    <= 1'b0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            blank_q   <= 1'b1;
            led_q     <= {COLS{1'b0}};
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            row_q     <= row_d;
            toggle_q  <= toggle_d;
            head_q    <= head_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            blank_q   <= blank_d;
            led_q     <= led_d;
        end
    end

    assign o_LED         = led_q;
    assign o_ROW         = row_q;
    assign o_BLANK       = blank_q;
    assign o_TOGGLE_SYNC = toggle_q;
    assign o_HEAD_FLAG   = head_q;
    assign o_SWAP_ACK    = ack_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Directed bench for led_scan_scheduler: per-cycle comparison of all outputs against a frame/bank model.
module tb_led_scan_scheduler;

    localparam int ROWS    = 32;
    localparam int COLS    = 32;
    localparam int ROW_PER = 69;

    logic        clk;
    logic        i_RESET;
    logic        i_ENA_p;
    logic        i_WR_EN;
    logic [4:0]  i_WR_ROW;
    logic [31:0] i_WR_DATA;
    logic        i_SWAP_REQ;
    logic [31:0] o_LED;
    logic [4:0]  o_ROW;
    logic        o_BLANK;
    logic        o_TOGGLE_SYNC;
    logic        o_HEAD_FLAG;
    logic        o_SWAP_ACK;
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [7:0]  i_BRIGHT;
`endif

    int          n_checks = 0;
    int          n_fails  = 0;

    logic [31:0] b_m [2][ROWS];
    bit          sel_m;
    int          row_m, p_m, bright_m;
    bit          tog_m, head_m, ack_due;

    led_scan_scheduler #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .BLANK_CYC (4),
        .ON_CYC    (64)
    ) dut (
        .i_CLK         (clk),
        .i_RESET       (i_RESET),
        .i_ENA_p       (i_ENA_p),
        .i_WR_EN       (i_WR_EN),
        .i_WR_ROW      (i_WR_ROW),
        .i_WR_DATA     (i_WR_DATA),
        .i_SWAP_REQ    (i_SWAP_REQ),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .i_BRIGHT      (i_BRIGHT),
`endif
        .o_LED         (o_LED),
        .o_ROW         (o_ROW),
        .o_BLANK       (o_BLANK),
        .o_TOGGLE_SYNC (o_TOGGLE_SYNC),
        .o_HEAD_FLAG   (o_HEAD_FLAG),
        .o_SWAP_ACK    (o_SWAP_ACK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (row_m=%0d p_m=%0d) at %0t", tag, obs, exp, row_m, p_m, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_led"},  o_LED, 32'd0);
        check_value({tag, "_row"},  {27'd0, o_ROW}, 32'd0);
        check_value({tag, "_blank"}, {31'd0, o_BLANK}, 32'd1);
        check_value({tag, "_tog"},  {31'd0, o_TOGGLE_SYNC}, 32'd0);
        check_value({tag, "_head"}, {31'd0, o_HEAD_FLAG}, 32'd0);
        check_value({tag, "_ack"},  {31'd0, o_SWAP_ACK}, 32'd0);
    endtask

    task automatic back_write(input int r, input logic [31:0] d);
        i_WR_EN   = 1'b1;
        i_WR_ROW  = 5'(r);
        i_WR_DATA = d;
        b_m[!sel_m][r] = d;
    endtask

    // Phase p_m: 0..3 blank, 4 load, 5..68 lit (subject to brightness).
    task automatic scan_cycles(input int n);
        bit          lit;
        logic [31:0] exp_led;
        for (int i = 0; i < n; i++) begin
            if (ack_due && row_m == 0 && p_m == 0) begin
                check_value("swap_ack", {31'd0, o_SWAP_ACK}, 32'd1);
                sel_m   = !sel_m;
                ack_due = 1'b0;
            end else begin
                check_value("ack_low", {31'd0, o_SWAP_ACK}, 32'd0);
            end
            lit     = (p_m >= 5) && ((p_m - 5) < bright_m);
            exp_led = lit ? b_m[sel_m][row_m] : 32'd0;
            check_value("row",   {27'd0, o_ROW}, 32'(row_m));
            check_value("blank", {31'd0, o_BLANK}, {31'd0, !lit});
            check_value("led",   o_LED, exp_led);
            check_value("tog",   {31'd0, o_TOGGLE_SYNC}, {31'd0, tog_m});
            check_value("head",  {31'd0, o_HEAD_FLAG}, {31'd0, head_m});
            tick();
            i_WR_EN    = 1'b0;
            i_SWAP_REQ = 1'b0;
            p_m++;
            if (p_m == ROW_PER) begin
                p_m    = 0;
                row_m  = (row_m + 1) % ROWS;
                tog_m  = !tog_m;
                head_m = (row_m == 0);
            end
        end
    endtask

    initial begin
        i_RESET    = 1'b1;
        i_ENA_p    = 1'b0;
        i_WR_EN    = 1'b0;
        i_WR_ROW   = 5'd0;
        i_WR_DATA  = 32'd0;
        i_SWAP_REQ = 1'b0;
        sel_m      = 1'b0;
        row_m      = 0;
        p_m        = 0;
        tog_m      = 1'b0;
        head_m     = 1'b0;
        ack_due    = 1'b0;
`ifdef LED_SCAN_BRIGHTNESS_EN
        i_BRIGHT   = 8'd16;
        bright_m   = 16;
`else
        bright_m   = 1000;
`endif
        tick();
        tick();
        check_reset_values("reset");
        i_RESET = 1'b0;
        tick();
        check_value("idle_blank", {31'd0, o_BLANK}, 32'd1);

        // Clear bank1, swap while idle, then clear bank0.
        for (int r = 0; r < ROWS; r++) begin
            back_write(r, 32'd0);
            tick();
        end
        i_WR_EN    = 1'b0;
        i_SWAP_REQ = 1'b1;
        tick();
        i_SWAP_REQ = 1'b0;
        check_value("idle_ack_pend", {31'd0, o_SWAP_ACK}, 32'd0);
        tick();
        check_value("idle_ack", {31'd0, o_SWAP_ACK}, 32'd1);
        sel_m = 1'b1;
        tick();
        check_value("idle_ack_clr", {31'd0, o_SWAP_ACK}, 32'd0);
        for (int r = 0; r < ROWS; r++) begin
            back_write(r, 32'd0);
            tick();
        end
        back_write(1, 32'h0000_0100);
        tick();
        i_WR_EN = 1'b0;

        // Frame 1: swap requested mid-frame, applied at end of row 31.
        i_ENA_p = 1'b1;
        tick();
        tog_m  = 1'b1;
        head_m = 1'b1;
        scan_cycles(10 * ROW_PER);
        i_SWAP_REQ = 1'b1;
        ack_due    = 1'b1;
        scan_cycles(22 * ROW_PER);

        // Frame 2: row 1 now lit; back[5] written on the very swap edge.
        scan_cycles(3 * ROW_PER);
        i_SWAP_REQ = 1'b1;
        ack_due    = 1'b1;
        scan_cycles(28 * ROW_PER + 68);
        back_write(5, 32'hA5A5_0005);
        scan_cycles(1);

        // Frame 3: drop enable during ON of row 7.
        scan_cycles(7 * ROW_PER + 30);
        i_ENA_p = 1'b0;
        scan_cycles(ROW_PER - 30);
        check_value("idle_row", {27'd0, o_ROW}, 32'd8);
        check_value("idle_led", o_LED, 32'd0);
        check_value("idle_tog", {31'd0, o_TOGGLE_SYNC}, {31'd0, !tog_m});
        repeat (3) tick();
        check_value("idle_blank2", {31'd0, o_BLANK}, 32'd1);
        check_value("idle_row2", {27'd0, o_ROW}, 32'd8);
        i_ENA_p = 1'b1;
        tick();
        scan_cycles(4 * ROW_PER + 20);

        // Reset during ON of row 12; front returns to bank0.
        i_RESET = 1'b1;
        tick();
        check_reset_values("midreset");
        i_RESET = 1'b0;
        sel_m   = 1'b0;
        tick();
        row_m   = 0;
        p_m     = 0;
        tog_m   = 1'b1;
        head_m  = 1'b1;
        ack_due = 1'b0;
        scan_cycles(2 * ROW_PER);
`ifdef LED_SCAN_BRIGHTNESS_EN
        i_BRIGHT = 8'd0;
        bright_m = 0;
        scan_cycles(ROW_PER);
        i_BRIGHT = 8'd200;
        bright_m = 200;
        scan_cycles(2 * ROW_PER);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
